// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader: FSM state encoding,
// the default frame start marker and the word/byte geometry helpers.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LENGTH,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loaderState_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE        = 8'hA5;
  localparam int         DEFAULT_INSTRUCTION_WIDTH = 24;
  localparam int         BYTES_PER_WORD            = DEFAULT_INSTRUCTION_WIDTH / 8;

  // Number of payload bytes that make up one instruction word.
  function automatic int bytesPerWord(input int instructionWidth);
    return instructionWidth / 8;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream and memory-write bundle of the program loader.
// master: the host/memory side (drives bytes, observes writes and status).
// slave:  the loader itself.
interface program_loader_if #(
  parameter int INSTRUCTION_WIDTH = 24,
  parameter int PC_WIDTH          = 8
);

  logic [7:0]                   byteData;
  logic                         byteValid;
  logic                         byteReady;
  logic                         memWriteEnable;
  logic [PC_WIDTH-1:0]          memWriteAddress;
  logic [INSTRUCTION_WIDTH-1:0] memWriteData;
  logic                         cpuHold;
  logic                         loadDone;
  logic                         loadError;

  modport master (
    output byteData, byteValid,
    input  byteReady, memWriteEnable, memWriteAddress, memWriteData,
           cpuHold, loadDone, loadError
  );

  modport slave (
    input  byteData, byteValid,
    output byteReady, memWriteEnable, memWriteAddress, memWriteData,
           cpuHold, loadDone, loadError
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Collects payload bytes MSB-first into instruction words. lastByte flags
// (combinationally) that the byte being offered completes a word; the
// finished word and its one-cycle wordValid strobe are registered.
module word_assembler
  import loader_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 24
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic                         clear,
  input  logic                         byteIn,
  input  logic [7:0]                   byteData,
  output logic                         lastByte,
  output logic                         wordValid,
  output logic [INSTRUCTION_WIDTH-1:0] word
);

  localparam int BPW = bytesPerWord(INSTRUCTION_WIDTH);
  localparam int COUNT_WIDTH = $clog2(BPW + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(BPW - 1);

  logic [COUNT_WIDTH-1:0]       byteCount;
  logic [INSTRUCTION_WIDTH-1:0] shiftReg;
  logic [INSTRUCTION_WIDTH-1:0] shifted;

  // Older bytes move up; after BPW bytes the first one sits in the MSBs.
  assign shifted  = (shiftReg << 8) | INSTRUCTION_WIDTH'(byteData);
  assign lastByte = (byteCount == LAST_INDEX);

  // Shift register, byte counter and registered word output.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      byteCount <= '0;
      shiftReg  <= '0;
      wordValid <= 1'b0;
      word      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wordValid <= 1'b0;
      if (clear) begin
        byteCount <= '0;
        shiftReg  <= '0;
      end else if (byteIn) begin
        shiftReg <= shifted;
        if (lastByte) begin
          byteCount <= '0;
          word      <= shifted;
          wordValid <= 1'b1;
        end else begin
          byteCount <= byteCount + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a framed program image into instruction memory:
// SYNC, N, N words of payload (MSB first), 8-bit additive checksum.
// Holds the CPU in reset from SYNC until a frame verifies.
module program_loader
  import loader_pkg::*;
#(
  parameter int         INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
  parameter int         PC_WIDTH          = 8,
  parameter logic [7:0] SYNC_BYTE         = DEFAULT_SYNC_BYTE
) (
  input logic             clock,
  input logic             isResetN,
  program_loader_if.slave bus
);

  loaderState_t        state;
  loaderState_t        nextState;
  logic                byteFire;
  logic                isSync;
  logic                checksumMatch;
  logic                lastByte;
  logic                assemblerClear;
  logic                assemblerByteIn;
  logic [8:0]          wordsLeft;
  logic [7:0]          checksum;
  logic [PC_WIDTH-1:0] writeAddress;

  assign bus.byteReady   = state inside {IDLE, LENGTH, DATA, CHECK};
  assign bus.loadDone    = (state == DONE);
  assign bus.memWriteAddress = writeAddress;
  assign byteFire        = bus.byteValid & bus.byteReady;
  assign isSync          = (bus.byteData == SYNC_BYTE);
  assign checksumMatch   = (bus.byteData == checksum);
  assign assemblerClear  = (state == LENGTH) && byteFire;
  assign assemblerByteIn = (state == DATA) && byteFire;

  word_assembler #(
    .INSTRUCTION_WIDTH(INSTRUCTION_WIDTH)
  ) u_wordAssembler (
    .clock    (clock),
    .isResetN (isResetN),
    .clear    (assemblerClear),
    .byteIn   (assemblerByteIn),
    .byteData (bus.byteData),
    .lastByte (lastByte),
    .wordValid(bus.memWriteEnable),
    .word     (bus.memWriteData)
  );

  // State register.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) state <= IDLE;
    else           state <= nextState;
  end

  // Next-state decode of the frame parser.
  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    nextState = state;
    case (state)
      IDLE:    if (byteFire && isSync) nextState = LENGTH;
      LENGTH:  if (byteFire) nextState = DATA;
      DATA:    if (byteFire && lastByte && (wordsLeft == 9'd1)) nextState = CHECK;
      CHECK:   if (byteFire) nextState = checksumMatch ? DONE : ERROR;
      DONE:    nextState = IDLE;
      ERROR:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Word counter and checksum accumulator; length 0 encodes 256 words.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      wordsLeft <= '0;
      checksum  <= '0;
    end else if (assemblerClear) begin
      wordsLeft <= (bus.byteData == 8'd0) ? 9'd256 : {1'b0, bus.byteData};
      checksum  <= '0;
    end else if (assemblerByteIn) begin
      checksum <= checksum + bus.byteData;
      if (lastByte) wordsLeft <= wordsLeft - 9'd1;
    end
  end

  // Write address: cleared at the length byte, advanced after each strobe.
  // Wraps naturally when the image is larger than the memory.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN)                writeAddress <= '0;
    else if (assemblerClear)      writeAddress <= '0;
    else if (bus.memWriteEnable)  writeAddress <= writeAddress + 1'b1;
  end

  // CPU hold and sticky error flag; a new SYNC starts a fresh attempt.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      bus.cpuHold   <= 1'b0;
      bus.loadError <= 1'b0;
    end else if ((state == IDLE) && byteFire && isSync) begin
      bus.cpuHold   <= 1'b1;
      bus.loadError <= 1'b0;
    end else if ((state == CHECK) && byteFire) begin
      if (checksumMatch) bus.cpuHold   <= 1'b0;
      else               bus.loadError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader. A frame-level reference model turns
// each payload into the list of (address, word) writes and the checksum
// outcome; a monitor compares every write strobe against that list.
module tb_program_loader;

  localparam int         IW       = 24;
  localparam int         PW       = 8;
  localparam int         BPW      = IW / 8;
  localparam logic [7:0] SYNC     = 8'hA5;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    logic [PW-1:0] addr;
    logic [IW-1:0] data;
  } write_t;

  logic clock;
  logic isResetN;

  program_loader_if #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) bus ();

  program_loader #(
    .INSTRUCTION_WIDTH(IW),
    .PC_WIDTH         (PW),
    .SYNC_BYTE        (SYNC)
  ) dut (
    .clock   (clock),
    .isResetN(isResetN),
    .bus     (bus)
  );

  int     total = 0;
  int     bad = 0;
  int     doneCount = 0;
  write_t expQ[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clock) begin
    if (isResetN) begin
      if (bus.loadDone) doneCount++;
      if (bus.memWriteEnable) begin
        if (expQ.size() == 0) begin
          check("unexpected write", 64'(bus.memWriteAddress), 64'hFFFF);
        end else begin
          write_t w;
          w = expQ.pop_front();
          check("write address", 64'(bus.memWriteAddress), 64'(w.addr));
          check("write data", 64'(bus.memWriteData), 64'(w.data));
        end
      end
    end
  end

  function automatic byteQ_t randomPayload(input int words);
    byteQ_t q;
    for (int i = 0; i < words * BPW; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference model: words MSB-first, consecutive addresses mod 2^PW.
  task automatic expectWrites(input byteQ_t payload, input int words);
    for (int k = 0; k < words; k++) begin
      write_t w;
      w.data = '0;
      for (int j = 0; j < BPW; j++) w.data = (w.data << 8) | IW'(payload[k * BPW + j]);
      w.addr = PW'(k % (1 << PW));
      expQ.push_back(w);
    end
  endtask

  // Offer one byte until it transfers; byteValid is randomised per cycle.
  task automatic sendByte(input logic [7:0] b, input int validPct);
    bit ok;
    ok = 0;
    bus.byteData = b;
    for (int budget = 0; budget < 200 && !ok; budget++) begin
      bus.byteValid = ($urandom_range(99) < validPct);
      @(negedge clock);
      ok = bus.byteValid && bus.byteReady;
      @(posedge clock);
      #1;
      bus.byteValid = 1'b0;
    end
    if (!ok) check("byte accept timeout", 64'd0, 64'd1);
  endtask

  task automatic sendFrame(input byteQ_t payload, input int nField, input bit corrupt,
                           input int validPct);
    logic [7:0] sum;
    int         words;
    int         doneBefore;
    sum   = 8'd0;
    words = (nField == 0) ? 256 : nField;
    foreach (payload[i]) sum = sum + payload[i];
    expectWrites(payload, words);
    doneBefore = doneCount;
    sendByte(SYNC, validPct);
    check("cpuHold after sync", 64'(bus.cpuHold), 64'd1);
    check("loadError after sync", 64'(bus.loadError), 64'd0);
    sendByte(8'(nField), validPct);
    foreach (payload[i]) sendByte(payload[i], validPct);
    sendByte(corrupt ? sum + 8'd1 : sum, validPct);
    check("loadDone after checksum", 64'(bus.loadDone), 64'(!corrupt));
    check("byteReady after checksum", 64'(bus.byteReady), 64'd0);
    check("cpuHold after checksum", 64'(bus.cpuHold), 64'(corrupt));
    check("loadError after checksum", 64'(bus.loadError), 64'(corrupt));
    @(posedge clock);
    #1;
    check("loadDone one cycle", 64'(bus.loadDone), 64'd0);
    check("byteReady back in idle", 64'(bus.byteReady), 64'd1);
    check("pending writes", 64'(expQ.size()), 64'd0);
    check("loadDone pulse count", 64'(doneCount - doneBefore), 64'(!corrupt));
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " byteReady"}, 64'(bus.byteReady), 64'd1);
    check({tag, " memWriteEnable"}, 64'(bus.memWriteEnable), 64'd0);
    check({tag, " memWriteAddress"}, 64'(bus.memWriteAddress), 64'd0);
    check({tag, " memWriteData"}, 64'(bus.memWriteData), 64'd0);
    check({tag, " cpuHold"}, 64'(bus.cpuHold), 64'd0);
    check({tag, " loadDone"}, 64'(bus.loadDone), 64'd0);
    check({tag, " loadError"}, 64'(bus.loadError), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byteQ_t fixedPayload;
    byteQ_t p;
    fixedPayload = '{8'h01, 8'h02, 8'h03, 8'h0A, 8'h0B, 8'h0C};

    isResetN      = 1'b0;
    bus.byteData  = 8'h00;
    bus.byteValid = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clock);
    isResetN = 1'b1;
    @(posedge clock);
    #1;

    // Directed frame, good checksum 0x27.
    sendFrame(fixedPayload, 2, 1'b0, 100);

    // Same frame, checksum 0x28: writes occur, error sticks, CPU stays held.
    sendFrame(fixedPayload, 2, 1'b1, 100);
    repeat (3) @(posedge clock);
    #1;
    check("cpuHold held after error", 64'(bus.cpuHold), 64'd1);
    check("loadError sticky", 64'(bus.loadError), 64'd1);

    // A good frame afterwards clears the error and releases the CPU.
    p = randomPayload(3);
    sendFrame(p, 3, 1'b0, 100);

    // Junk before sync is discarded.
    sendByte(8'h00, 100);
    sendByte(8'hFF, 100);
    sendByte(8'h13, 100);
    check("cpuHold after junk", 64'(bus.cpuHold), 64'd0);
    check("writes after junk", 64'(expQ.size()), 64'd0);
    sendFrame(fixedPayload, 2, 1'b0, 100);

    // Throttled valid: same write sequence as back-to-back.
    sendFrame(fixedPayload, 2, 1'b0, 50);
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(8, 1);
      p = randomPayload(n);
      if (f == 1) p[1] = SYNC;
      sendFrame(p, n, 1'b0, 50);
    end
    p = randomPayload(2);
    sendFrame(p, 2, 1'b1, 50);

    // Length 0 means 256 words covering the whole address space.
    p = randomPayload(256);
    sendFrame(p, 0, 1'b0, 100);

    // Reset after the 4th payload byte: only the first word is written.
    p = randomPayload(2);
    expectWrites(p, 1);
    sendByte(SYNC, 100);
    sendByte(8'd2, 100);
    for (int i = 0; i < 4; i++) sendByte(p[i], 100);
    #2;
    isResetN = 1'b0;
    #1;
    checkResetValues("mid-frame reset");
    check("writes before reset", 64'(expQ.size()), 64'd0);
    @(negedge clock);
    isResetN = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("no write after reset", 64'(expQ.size()), 64'd0);
    p = randomPayload(4);
    sendFrame(p, 4, 1'b0, 100);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program into the instruction memory that the CPU fetches from. Takes a byte stream over a valid/ready handshake, assembles instruction words MSB-first, writes them to consecutive addresses, and verifies a trailing checksum. Holds the CPU in reset while loading. Sits between the serial/host front end and the write port of instruction memory; its `cpuHold` output is ORed into the CPU's `isReset`.

## Interface
- `INSTRUCTION_WIDTH`, 24: instruction word width; must be a multiple of 8.
- `PC_WIDTH`, 8: instruction memory address width.
- `SYNC_BYTE`, 8'hA5: frame start marker.

- `clock`  in  1  system clock, rising edge.
- `isResetN`  in  1  asynchronous, active-low reset.
- `byteData`  in  8  incoming byte.
- `byteValid`  in  1  `byteData` valid.
- `byteReady`  out  1  loader can accept a byte; a byte transfers when `byteValid & byteReady`.
- `memWriteEnable`  out  1  one-cycle write strobe.
- `memWriteAddress`  out  PC_WIDTH  write address.
- `memWriteData`  out  INSTRUCTION_WIDTH  word to write.
- `cpuHold`  out  1  CPU held in reset.
- `loadDone`  out  1  one-cycle pulse on a successful load.
- `loadError`  out  1  sticky checksum failure flag.

## Operation
- Frame format: `SYNC_BYTE`, length byte N, N×(INSTRUCTION_WIDTH/8) payload bytes (MSB first per word), checksum byte = 8-bit modulo sum of all payload bytes. Sync and length bytes are excluded from the sum.
- N = 0 means 256 words.
- State machine:
  - `IDLE` → `LENGTH` on accepted byte == `SYNC_BYTE`. Other bytes are accepted and discarded.
  - `LENGTH` → `DATA`: latch N, clear address, checksum and byte counter.
  - `DATA`: shift each accepted byte into the word assembler and add it to the checksum. On the last byte of a word, register the word and pulse `memWriteEnable` at the current address, then increment the address. After the last byte of the last word → `CHECK`.
  - `CHECK`: on the accepted byte, go to `DONE` if it equals the running sum, otherwise `ERROR`.
  - `DONE` (1 cycle): pulse `loadDone` → `IDLE`.
  - `ERROR` → `IDLE` in the next cycle.
- `cpuHold`:
  - Set when `SYNC_BYTE` is accepted in `IDLE`.
  - Cleared only in `DONE`.
  - Remains set after `ERROR`, so the CPU never runs a partial or corrupt image; a later good frame releases it.
- `loadError`: set on entry to `ERROR`; cleared when a new `SYNC_BYTE` is accepted.
- Address wraps modulo 2^PC_WIDTH when N exceeds memory depth; no error is raised.
- A `SYNC_BYTE` value inside `DATA` or `CHECK` is ordinary data; there is no resynchronisation mid-frame.

## Timing
- Reset values:
  - state `IDLE`
  - `byteReady` = 1
  - `memWriteEnable` = 0
  - `memWriteAddress` = 0
  - `memWriteData` = 0
  - `cpuHold` = 0
  - `loadDone` = 0
  - `loadError` = 0
- `byteReady` = 1 in `IDLE`, `LENGTH`, `DATA`, `CHECK`; 0 in `DONE` and `ERROR`.
- Write latency: `memWriteEnable`, `memWriteAddress` and `memWriteData` are registered. They are valid in the cycle after the word's last byte transfers. The address increments in the cycle after the strobe.
- Back-to-back bytes at one per cycle are sustained; there are no stalls inside `DATA`.
- `loadDone` is high for exactly the one cycle after the checksum byte transfers. `cpuHold` falls on that same edge.
- `byteValid` low simply stalls; there is no timeout.
- Reset asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - `cpuHold` drops, so the CPU restarts on whatever memory holds; the host is responsible for re-sending.

## Structure
- Package `loader_pkg`: state enum (`IDLE`, `LENGTH`, `DATA`, `CHECK`, `DONE`, `ERROR`), default `SYNC_BYTE`, and `BYTES_PER_WORD = INSTRUCTION_WIDTH/8`.
- Sub-module `word_assembler`: shift register plus byte counter. Emits `wordValid` with the assembled word; reset by the FSM at `LENGTH`.
- Top-level `program_loader`: FSM, length/word counter, address counter, checksum accumulator, hold/error flags.

## Test plan
- Frame A5 02 | 01 02 03 | 0A 0B 0C | 27, one byte per cycle → writes 0x010203 @0 and 0x0A0B0C @1. `loadDone` pulses once; `cpuHold` high from the cycle after A5 until `loadDone`; `loadError` = 0.
- Same frame with checksum 28 → both writes occur, `loadError` = 1, `cpuHold` stays 1, no `loadDone`. Then send a correct frame → `loadError` clears on its A5, and `cpuHold` releases at its end.
- Bytes 00 FF 13 before A5 → discarded with no writes; the subsequent frame loads normally.
- `byteValid` toggled randomly 50% during a frame → identical writes and address sequence to the back-to-back case.
- Length 00 with PC_WIDTH = 8 and 768 payload bytes → 256 writes at addresses 0..255, then the checksum is evaluated.
- `isResetN` pulsed low after the 4th payload byte → all outputs at reset values immediately, no further writes. A following full frame loads correctly from address 0.
